// File: rtl/temac_cfg_pkg.sv
// Shared constants for the TEMAC configuration register window:
// register offsets, AXI response codes and the enable bit position.
package temac_cfg_pkg;

  localparam logic [31:0] OFF_ID        = 32'h0000_0000;
  localparam logic [31:0] OFF_RCW1      = 32'h0000_0404;
  localparam logic [31:0] OFF_TCW       = 32'h0000_0408;
  localparam logic [31:0] OFF_FILT_PORT = 32'h0000_0500;
  localparam logic [31:0] OFF_STATUS    = 32'h0000_0504;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int EN_BIT = 28;

  typedef enum logic [2:0] {
    REG_ID,
    REG_RCW1,
    REG_TCW,
    REG_FILT_PORT,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  // Offset must already be masked to the decoded window, word aligned.
  function automatic reg_sel_e decode_off(input logic [31:0] off);
    reg_sel_e sel;
    case (off)
      OFF_ID:        sel = REG_ID;
      OFF_RCW1:      sel = REG_RCW1;
      OFF_TCW:       sel = REG_TCW;
      OFF_FILT_PORT: sel = REG_FILT_PORT;
      OFF_STATUS:    sel = REG_STATUS;
      default:       sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge of a stored value with write data under byte strobes.
// W must be a multiple of 8.
module axil_wstrb_merge #(
  parameter int W = 32
) (
  input  logic [W-1:0]   old_i,
  input  logic [W-1:0]   wdata_i,
  input  logic [W/8-1:0] wstrb_i,
  output logic [W-1:0]   merged_o
);

  for (genvar b = 0; b < W / 8; b++) begin : g_lane
    assign merged_o[8*b +: 8] = wstrb_i[b] ? wdata_i[8*b +: 8] : old_i[8*b +: 8];
  end

endmodule

// File: rtl/temac_cfg_axil_slave.sv
// AXI4-Lite responder for the TEMAC configuration window (ID, RCW1, TCW,
// UDP filter port, STATUS). Independent write and read channels.
module temac_cfg_axil_slave
  import temac_cfg_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = 32'h5544_5046,
  parameter logic [31:0] RCW1_RST = 32'h0000_0000,
  parameter logic [31:0] TCW_RST  = 32'h0000_0000,
  parameter logic [15:0] PORT_RST = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        stat_link_up,
  input  logic [15:0] stat_frames_dropped,
  output logic        rx_enable,
  output logic        tx_enable,
  output logic [15:0] filt_udp_port
);

  localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_W) - 64'd1) & 32'hFFFF_FFFC;

  logic        aw_full_q, aw_full_d;
  logic [31:0] aw_off_q, aw_off_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rcw1_q, rcw1_d;
  logic [31:0] tcw_q, tcw_d;
  logic [15:0] port_q, port_d;

  logic [31:0] rcw1_merged, tcw_merged;
  logic [15:0] port_merged;
  logic [31:0] status_word;
  logic        commit;

  axil_wstrb_merge #(.W(32)) u_merge_rcw1 (
    .old_i   (rcw1_q),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .merged_o(rcw1_merged)
  );

  axil_wstrb_merge #(.W(32)) u_merge_tcw (
    .old_i   (tcw_q),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .merged_o(tcw_merged)
  );

  // Only the low two lanes exist in storage; upper lanes are discarded.
  axil_wstrb_merge #(.W(16)) u_merge_port (
    .old_i   (port_q),
    .wdata_i (w_data_q[15:0]),
    .wstrb_i (w_strb_q[1:0]),
    .merged_o(port_merged)
  );

  assign status_word = {15'b0, stat_link_up, stat_frames_dropped};
  assign commit      = aw_full_q & w_full_q & ~bvalid_q;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_off_d  = aw_off_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rcw1_d    = rcw1_q;
    tcw_d     = tcw_q;
    port_d    = port_q;

    if (s_axi_awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_off_d  = s_axi_awaddr & ADDR_MASK;
    end
    if (s_axi_wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end

    if (commit) begin
      bvalid_d = 1'b1;
      case (decode_off(aw_off_q))
        REG_RCW1: begin
          rcw1_d  = rcw1_merged;
          bresp_d = RESP_OKAY;
        end
        REG_TCW: begin
          tcw_d   = tcw_merged;
          bresp_d = RESP_OKAY;
        end
        REG_FILT_PORT: begin
          port_d  = port_merged;
          bresp_d = RESP_OKAY;
        end
        REG_ID, REG_STATUS: bresp_d = RESP_SLVERR;
        default:            bresp_d = RESP_DECERR;
      endcase
    end

    // Entries stay occupied until the response is taken, which holds the readies low.
    if (bvalid_q && s_axi_bready) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (s_axi_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (decode_off(s_axi_araddr & ADDR_MASK))
        REG_ID:        rdata_d = ID_VALUE;
        REG_RCW1:      rdata_d = rcw1_q;
        REG_TCW:       rdata_d = tcw_q;
        REG_FILT_PORT: rdata_d = {16'b0, port_q};
        REG_STATUS:    rdata_d = status_word;
        default: begin
          rdata_d = 32'b0;
          rresp_d = RESP_DECERR;
        end
      endcase
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      aw_off_q  <= 32'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= 32'b0;
      w_strb_q  <= 4'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'b0;
      rresp_q   <= RESP_OKAY;
      rcw1_q    <= RCW1_RST;
      tcw_q     <= TCW_RST;
      port_q    <= PORT_RST;
    end else begin
      aw_full_q <= aw_full_d;
      aw_off_q  <= aw_off_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rcw1_q    <= rcw1_d;
      tcw_q     <= tcw_d;
      port_q    <= port_d;
    end
  end

  assign s_axi_awready = ~aw_full_q;
  assign s_axi_wready  = ~w_full_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ~rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign rx_enable     = rcw1_q[EN_BIT];
  assign tx_enable     = tcw_q[EN_BIT];
  assign filt_udp_port = port_q;

endmodule

// File: tb/tb_temac_cfg_axil_slave.sv
// Bench for temac_cfg_axil_slave: directed register-map cases followed by
// randomized traffic checked against a register-map reference model.
module tb_temac_cfg_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        stat_link_up = 1'b0;
  logic [15:0] stat_frames_dropped = '0;
  logic        rx_enable;
  logic        tx_enable;
  logic [15:0] filt_udp_port;

  temac_cfg_axil_slave dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axi_awaddr       (s_axi_awaddr),
    .s_axi_awvalid      (s_axi_awvalid),
    .s_axi_awready      (s_axi_awready),
    .s_axi_wdata        (s_axi_wdata),
    .s_axi_wstrb        (s_axi_wstrb),
    .s_axi_wvalid       (s_axi_wvalid),
    .s_axi_wready       (s_axi_wready),
    .s_axi_bresp        (s_axi_bresp),
    .s_axi_bvalid       (s_axi_bvalid),
    .s_axi_bready       (s_axi_bready),
    .s_axi_araddr       (s_axi_araddr),
    .s_axi_arvalid      (s_axi_arvalid),
    .s_axi_arready      (s_axi_arready),
    .s_axi_rdata        (s_axi_rdata),
    .s_axi_rresp        (s_axi_rresp),
    .s_axi_rvalid       (s_axi_rvalid),
    .s_axi_rready       (s_axi_rready),
    .stat_link_up       (stat_link_up),
    .stat_frames_dropped(stat_frames_dropped),
    .rx_enable          (rx_enable),
    .tx_enable          (tx_enable),
    .filt_udp_port      (filt_udp_port)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ID_V = 32'h5544_5046;

  int passed = 0;
  int total = 0;

  // Reference model: the three writable registers as plain values.
  logic [31:0] m_rcw1 = 32'h0;
  logic [31:0] m_tcw  = 32'h0;
  logic [31:0] m_port = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word_off(input logic [31:0] a);
    return ((a % 32'h1000) / 4) * 4;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] v = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    case (word_off(a))
      32'h404: begin m_rcw1 = lane_merge(m_rcw1, d, s); resp = 2'b00; end
      32'h408: begin m_tcw = lane_merge(m_tcw, d, s); resp = 2'b00; end
      32'h500: begin m_port = lane_merge(m_port, d, s) & 32'h0000_FFFF; resp = 2'b00; end
      32'h000, 32'h504: resp = 2'b10;
      default: resp = 2'b11;
    endcase
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    case (word_off(a))
      32'h000: d = ID_V;
      32'h404: d = m_rcw1;
      32'h408: d = m_tcw;
      32'h500: d = m_port;
      32'h504: d = {15'b0, stat_link_up, stat_frames_dropped};
      default: begin d = 32'h0; resp = 2'b11; end
    endcase
  endtask

  // wlead > 0: W leads AW by wlead cycles; wlead < 0: AW leads W.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int wlead, input int bdelay,
                           output logic [1:0] resp, output int lat);
    int cyc = 0, aw_c = -1, w_c = -1, bv_c = -1, bwait = 0;
    int aw_start, w_start;
    bit awd = 0, wd = 0, bd = 0, hs_aw, hs_w, hs_b;
    aw_start = (wlead > 0) ? wlead : 0;
    w_start  = (wlead < 0) ? -wlead : 0;
    resp = 2'bxx;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_bready  = 1'b0;
    s_axi_awvalid = (aw_start == 0);
    s_axi_wvalid  = (w_start == 0);
    while (!bd && cyc < 100) begin
      @(negedge clk);
      if (awd && !bd) check("awready_held", {31'b0, s_axi_awready}, 32'd0);
      if (wd && !bd) check("wready_held", {31'b0, s_axi_wready}, 32'd0);
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      if (hs_aw) aw_c = cyc;
      if (hs_w) w_c = cyc;
      if (s_axi_bvalid) begin
        if (bv_c < 0) begin
          bv_c = cyc;
          resp = s_axi_bresp;
        end else begin
          check("bresp_hold", {30'b0, s_axi_bresp}, {30'b0, resp});
        end
        if (bwait >= bdelay) s_axi_bready = 1'b1;
        bwait++;
      end
      hs_b = s_axi_bvalid && s_axi_bready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs_aw) begin s_axi_awvalid = 1'b0; awd = 1; end
      if (hs_w) begin s_axi_wvalid = 1'b0; wd = 1; end
      if (!awd && cyc == aw_start) s_axi_awvalid = 1'b1;
      if (!wd && cyc == w_start) s_axi_wvalid = 1'b1;
      if (hs_b) begin s_axi_bready = 1'b0; bd = 1; end
    end
    check("write_done", {31'b0, bd}, 32'd1);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    lat = bv_c - ((aw_c > w_c) ? aw_c : w_c);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdelay,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
    int cyc = 0, hs_c = -1, rv_c = -1, wt = 0;
    bit done = 0, hs, rh;
    d = 32'hx;
    resp = 2'bxx;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      hs = s_axi_arvalid && s_axi_arready;
      if (hs) hs_c = cyc;
      if (s_axi_rvalid) begin
        if (rv_c < 0) begin
          rv_c = cyc;
          d = s_axi_rdata;
          resp = s_axi_rresp;
        end else begin
          check("rdata_hold", s_axi_rdata, d);
          check("rresp_hold", {30'b0, s_axi_rresp}, {30'b0, resp});
        end
        check("arready_low", {31'b0, s_axi_arready}, 32'd0);
        if (wt >= rdelay) s_axi_rready = 1'b1;
        wt++;
      end
      rh = s_axi_rvalid && s_axi_rready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) s_axi_arvalid = 1'b0;
      if (rh) begin s_axi_rready = 1'b0; done = 1; end
    end
    check("read_done", {31'b0, done}, 32'd1);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    lat = rv_c - hs_c;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rx_enable"}, {31'b0, rx_enable}, {31'b0, m_rcw1[28]});
    check({tag, "_tx_enable"}, {31'b0, tx_enable}, {31'b0, m_tcw[28]});
    check({tag, "_filt_port"}, {16'b0, filt_udp_port}, m_port);
  endtask

  initial begin
    logic [1:0]  resp, eresp;
    logic [31:0] rd, erd, addr, data;
    logic [3:0]  strb;
    logic [31:0] off_tab [7];
    int lat;

    off_tab[0] = 32'h000; off_tab[1] = 32'h404; off_tab[2] = 32'h408;
    off_tab[3] = 32'h500; off_tab[4] = 32'h504; off_tab[5] = 32'h7F0;
    off_tab[6] = 32'h0C8;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_awready", {31'b0, s_axi_awready}, 32'd1);
    check("rst_wready", {31'b0, s_axi_wready}, 32'd1);
    check("rst_arready", {31'b0, s_axi_arready}, 32'd1);
    check("rst_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, s_axi_rvalid}, 32'd0);
    check("rst_bresp", {30'b0, s_axi_bresp}, 32'd0);
    check("rst_rresp", {30'b0, s_axi_rresp}, 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check_outputs("rst");

    // AW and W together on RCW1
    axi_write(32'h404, 32'h1000_0000, 4'hF, 0, 0, resp, lat);
    model_write(32'h404, 32'h1000_0000, 4'hF, eresp);
    check("t1_bresp", {30'b0, resp}, {30'b0, eresp});
    check("t1_blat", lat, 2);
    check_outputs("t1");
    axi_read(32'h404, 0, rd, resp, lat);
    check("t1_rdata", rd, 32'h1000_0000);
    check("t1_rresp", {30'b0, resp}, 32'd0);
    check("t1_rlat", lat, 1);

    // W three cycles ahead of AW on TCW
    axi_write(32'h408, 32'h1000_0000, 4'hF, 3, 0, resp, lat);
    model_write(32'h408, 32'h1000_0000, 4'hF, eresp);
    check("t2_bresp", {30'b0, resp}, 32'd0);
    check("t2_blat", lat, 2);
    check_outputs("t2");

    // Single-lane write to the filter port from reset
    axi_write(32'h500, 32'hABCD_1234, 4'h1, 0, 0, resp, lat);
    model_write(32'h500, 32'hABCD_1234, 4'h1, eresp);
    check("t3_bresp", {30'b0, resp}, 32'd0);
    check("t3_port", {16'b0, filt_udp_port}, 32'h0000_0034);
    axi_read(32'h500, 0, rd, resp, lat);
    check("t3_rdata", rd, 32'h0000_0034);

    // Read-only and unmapped offsets
    axi_write(32'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
    check("t4_id_bresp", {30'b0, resp}, 32'd2);
    axi_read(32'h000, 0, rd, resp, lat);
    check("t4_id_rdata", rd, ID_V);
    check("t4_id_rresp", {30'b0, resp}, 32'd0);
    axi_write(32'h7F0, 32'h1234_5678, 4'hF, -1, 0, resp, lat);
    check("t4_dec_bresp", {30'b0, resp}, 32'd3);
    axi_read(32'h7F0, 0, rd, resp, lat);
    check("t4_dec_rdata", rd, 32'd0);
    check("t4_dec_rresp", {30'b0, resp}, 32'd3);
    check_outputs("t4");

    // Backpressure on B and R
    axi_write(32'h404, 32'h0000_00A5, 4'hF, 0, 5, resp, lat);
    model_write(32'h404, 32'h0000_00A5, 4'hF, eresp);
    check("t5_bresp", {30'b0, resp}, 32'd0);
    check_outputs("t5");
    stat_link_up = 1'b1;
    stat_frames_dropped = 16'h0007;
    axi_read(32'h504, 4, rd, resp, lat);
    check("t5_status", rd, 32'h0001_0007);
    check("t5_status_rresp", {30'b0, resp}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      addr = {$urandom_range(0, 32'hFFFFF), 12'h000} |
             off_tab[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      axi_write(addr, data, strb, $urandom_range(0, 4) - 2, $urandom_range(0, 2), resp, lat);
      model_write(addr, data, strb, eresp);
      check("rnd_bresp", {30'b0, resp}, {30'b0, eresp});
      check_outputs("rnd");
      stat_link_up = 1'($urandom_range(0, 1));
      stat_frames_dropped = 16'($urandom);
      addr = {$urandom_range(0, 32'hFFFFF), 12'h000} |
             off_tab[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
      axi_read(addr, $urandom_range(0, 2), rd, resp, lat);
      model_read(addr, erd, eresp);
      check("rnd_rdata", rd, erd);
      check("rnd_rresp", {30'b0, resp}, {30'b0, eresp});
    end

    // Reset while a write response is pending
    axi_write(32'h404, 32'h1000_0000, 4'hF, 0, 0, resp, lat);
    model_write(32'h404, 32'h1000_0000, 4'hF, eresp);
    s_axi_awaddr  = 32'h408;
    s_axi_wdata   = 32'h1000_0000;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b0;
    @(posedge clk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    for (int i = 0; i < 10 && !s_axi_bvalid; i++) @(negedge clk);
    check("rst6_pre_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
    check("rst6_pre_rx", {31'b0, rx_enable}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_rcw1 = 32'h0;
    m_tcw  = 32'h0;
    m_port = 32'h0;
    check("rst6_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
    check("rst6_awready", {31'b0, s_axi_awready}, 32'd1);
    check("rst6_wready", {31'b0, s_axi_wready}, 32'd1);
    check("rst6_arready", {31'b0, s_axi_arready}, 32'd1);
    check_outputs("rst6");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst6_post_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
    check_outputs("rst6_post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/temac_cfg_axil_slave.md
Name: temac_cfg_axil_slave

Overview:
AXI4-Lite responder that implements the TEMAC-compatible configuration register window: RX config word 1, TX config word, a UDP filter port register, plus read-only ID and status. It is the slave end of the config bus driven by the init master. It decodes single-beat writes and reads, applies byte strobes and returns OKAY, SLVERR or DECERR. It drives rx_enable, tx_enable and filt_udp_port to the MAC datapath and the UDP filter.

Parameters:
ADDR_W, 12, number of low address bits decoded; bits [31:ADDR_W] ignored; bits [1:0] ignored
ID_VALUE, 32'h5544_5046, value returned by the ID register
RCW1_RST, 32'h0000_0000, reset value of RCW1
TCW_RST, 32'h0000_0000, reset value of TCW
PORT_RST, 16'd0, reset value of filter UDP port

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_axi_awaddr  in  32  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read valid
s_axi_rready  in  1  read ready
stat_link_up  in  1  link status from the PHY side, synchronous to clk
stat_frames_dropped  in  16  filter drop counter snapshot
rx_enable  out  1  RCW1[28]
tx_enable  out  1  TCW[28]
filt_udp_port  out  16  FILT_PORT[15:0]

Behaviour:
- Register map (word offsets after masking to ADDR_W):
  - 0x000 ID, RO = ID_VALUE
  - 0x404 RCW1, RW 32 bits
  - 0x408 TCW, RW 32 bits
  - 0x500 FILT_PORT, RW; bits [15:0] stored, [31:16] read 0, writes to [31:16] discarded
  - 0x504 STATUS, RO = {15'b0, stat_link_up, stat_frames_dropped}
- Responses: OKAY 2'b00. Write to ID or STATUS gives SLVERR 2'b10 with no state change. Any unmapped offset, read or write, gives DECERR 2'b11; unmapped reads return rdata 0.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, RCW1=RCW1_RST, TCW=TCW_RST, FILT_PORT=PORT_RST.
- Write path: AW and W are accepted independently. Each has a one-entry holding register.
  - awready=0 while the AW entry is held; wready=0 while the W entry is held. Each ready returns to 1 in the cycle after its B handshake completes.
  - Commit happens in the first cycle in which both entries are held and bvalid=0. In that cycle: registers update per wstrb byte lanes, bresp is set, and bvalid goes to 1 on the next edge.
  - AW and W handshaking in the same cycle gives bvalid 2 cycles after that edge (capture edge, then commit edge).
  - bvalid is held with bresp stable until bready=1. The holding entries free on the B handshake edge.
- Read path: when arvalid and arready are both 1, the address is decoded and rdata/rresp are registered at that edge. rvalid=1 the next cycle and arready=0.
  - rvalid, rdata and rresp are held stable until rready=1. On that handshake rvalid=0 and arready=1 on the next edge.
  - Maximum throughput is one read per two cycles.
- Read captured in the same cycle as a write commit to the same register returns the pre-write value.
- Read and write channels are fully independent; there is no ordering between them.
- wstrb=0 on a mapped RW register: no data change, response OKAY.
- Outputs rx_enable, tx_enable and filt_udp_port are registered directly from storage. They change on the commit edge.
- rst_n assertion mid-transaction: all handshakes abort, registers return to reset values and pending responses are dropped.
- VALID/READY rules: the slave never waits on bready or rready before asserting bvalid or rvalid. Outputs never depend combinationally on the valid inputs.

Decomposition:
- Shared package temac_cfg_pkg:
  - register offset constants OFF_ID, OFF_RCW1 (0x404), OFF_TCW (0x408), OFF_FILT_PORT, OFF_STATUS
  - RESP_OKAY, RESP_SLVERR, RESP_DECERR
  - bit index EN_BIT = 28
- One sub-module, axil_wstrb_merge: combinational byte-lane merge of old value, wdata and wstrb. It is reused for every RW register.

Test Plan:
- AW and W in the same cycle: 0x404 with 0x1000_0000, wstrb 0xF -> bvalid 2 cycles later with bresp 00; rx_enable=1; a read of 0x404 returns 0x1000_0000.
- W issued 3 cycles before AW, on 0x408 with 0x1000_0000 -> wready low after W until B completes; commit after AW; tx_enable=1; bresp 00.
- Write 0x500 with 0xABCD_1234, wstrb 0x1 -> filt_udp_port=0x0034 from reset; a read returns 0x0000_0034.
- Write to 0x000 -> bresp 10 and ID unchanged; write or read at 0x7F0 -> resp 11 with rdata 0.
- bready held low for 5 cycles -> bvalid and bresp stay stable and awready stays 0. Then rready held low on a read of 0x504 with link_up=1 and drops=0x0007 -> rdata 0x0001_0007 stable until rready.
- rst_n pulsed low while bvalid=1 and RCW1=0x1000_0000 -> bvalid=0, rx_enable=0 and all readies=1 immediately.
